// File: rtl/tpu_tile_sequencer.sv
// Job sequencer for the systolic TPU tile: weight select/reload, UB row streaming, delayed result writes.
// Optional busy-cycle counter output perf_cycles is enabled by defining TPU_SEQ_PERF_CNT_EN.
module tpu_tile_sequencer #(
  parameter int ADDRESSSIZE = 10,
  parameter int WADDR_BW    = 2,
  parameter int PIPE_LAT    = 32
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic                   abort,
  input  logic [ADDRESSSIZE-1:0] num_rows,
  input  logic [ADDRESSSIZE-1:0] ub_base,
  input  logic [ADDRESSSIZE-1:0] res_base,
  input  logic [WADDR_BW-1:0]    weight_sel,
  output logic                   busy,
  output logic                   done,
  output logic [WADDR_BW-1:0]    weight_addr,
  output logic                   we_rl,
  output logic                   ub_rd_en,
  output logic [ADDRESSSIZE-1:0] ub_addr,
  output logic                   res_we,
  output logic [ADDRESSSIZE-1:0] res_addr
`ifdef TPU_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]            perf_cycles
`endif
);

  localparam int CW = ADDRESSSIZE + 1;
  localparam int XW = ADDRESSSIZE + 2;
  localparam logic [CW-1:0]          PL_C = CW'(PIPE_LAT);
  localparam logic [XW-1:0]          PL_X = XW'(PIPE_LAT);
  localparam logic [ADDRESSSIZE-1:0] PL_A = ADDRESSSIZE'(PIPE_LAT);

  typedef enum logic [2:0] {
    S_IDLE, S_WADDR, S_WLOAD, S_STREAM, S_DRAIN, S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cyc_q, cyc_d;
  logic [ADDRESSSIZE-1:0] rows_q, rows_d;
  logic [ADDRESSSIZE-1:0] ub_base_q, ub_base_d;
  logic [ADDRESSSIZE-1:0] res_base_q, res_base_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [WADDR_BW-1:0]    weight_addr_q, weight_addr_d;
  logic                   we_rl_q, we_rl_d;
  logic                   ub_rd_en_q, ub_rd_en_d;
  logic [ADDRESSSIZE-1:0] ub_addr_q, ub_addr_d;
  logic                   res_we_q, res_we_d;
  logic [ADDRESSSIZE-1:0] res_addr_q, res_addr_d;

  logic accept, kill, last_rd, last_wr, in_win;

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    rows_d     = rows_q;
    ub_base_d  = ub_base_q;
    res_base_d = res_base_q;
    accept     = (state_q == S_IDLE) && start;
    kill       = (state_q != S_IDLE) && abort;
    last_rd    = (cyc_q == ({1'b0, rows_q} - CW'(1)));
    // Last write happens at cyc == PIPE_LAT + rows - 1; compared with one spare bit.
    last_wr    = ({1'b0, cyc_q} + XW'(1)) == (PL_X + {2'b00, rows_q});

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_WADDR;
          rows_d     = num_rows;
          ub_base_d  = ub_base;
          res_base_d = res_base;
        end
      end
      S_WADDR: state_d = S_WLOAD;
      S_WLOAD: begin
        cyc_d   = '0;
        state_d = (rows_q == '0) ? S_DONE : S_STREAM;
      end
      S_STREAM: begin
        cyc_d = cyc_q + CW'(1);
        if (last_rd) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        cyc_d = cyc_q + CW'(1);
        if (last_wr) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (kill) begin
      state_d = S_IDLE;
      cyc_d   = '0;
    end
  end

  // Outputs are registered, decoded from the next state so they align with it.
  always_comb begin
    busy_d        = (state_d != S_IDLE);
    done_d        = (state_d == S_DONE);
    we_rl_d       = (state_d == S_WLOAD);
    ub_rd_en_d    = (state_d == S_STREAM);
    ub_addr_d     = ub_rd_en_d ? (ub_base_q + cyc_d[ADDRESSSIZE-1:0]) : '0;
    in_win        = ((state_d == S_STREAM) || (state_d == S_DRAIN)) &&
                    (cyc_d >= PL_C) &&
                    ({1'b0, cyc_d} < (PL_X + {2'b00, rows_q}));
    res_we_d      = in_win;
    res_addr_d    = in_win ? (res_base_q + (cyc_d[ADDRESSSIZE-1:0] - PL_A)) : '0;
    weight_addr_d = weight_addr_q;
    if (kill)        weight_addr_d = '0;
    else if (accept) weight_addr_d = weight_sel;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= S_IDLE;
      cyc_q         <= '0;
      rows_q        <= '0;
      ub_base_q     <= '0;
      res_base_q    <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      weight_addr_q <= '0;
      we_rl_q       <= 1'b0;
      ub_rd_en_q    <= 1'b0;
      ub_addr_q     <= '0;
      res_we_q      <= 1'b0;
      res_addr_q    <= '0;
    end else begin
      state_q       <= state_d;
      cyc_q         <= cyc_d;
      rows_q        <= rows_d;
      ub_base_q     <= ub_base_d;
      res_base_q    <= res_base_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      weight_addr_q <= weight_addr_d;
      we_rl_q       <= we_rl_d;
      ub_rd_en_q    <= ub_rd_en_d;
      ub_addr_q     <= ub_addr_d;
      res_we_q      <= res_we_d;
      res_addr_q    <= res_addr_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign weight_addr = weight_addr_q;
  assign we_rl       = we_rl_q;
  assign ub_rd_en    = ub_rd_en_q;
  assign ub_addr     = ub_addr_q;
  assign res_we      = res_we_q;
  assign res_addr    = res_addr_q;

`ifdef TPU_SEQ_PERF_CNT_EN
  logic [31:0] perf_q, perf_d;

  // Counts each cycle busy was high; cleared on accept, held after the job ends.
  always_comb begin
    perf_d = perf_q;
    if (accept)                        perf_d = '0;
    else if (busy_q && (perf_q != '1)) perf_d = perf_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) perf_q <= '0;
    else       perf_q <= perf_d;
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_tpu_tile_sequencer.sv
// Randomized bench for tpu_tile_sequencer against a per-job timeline model (offset k from the accept edge).
module tb_tpu_tile_sequencer;
  localparam int A = 10;
  localparam int W = 2;
  localparam int P = 32;
  localparam int AMOD = 1 << A;

  logic         clk = 1'b0;
  logic         rstn;
  logic         start, abort;
  logic [A-1:0] num_rows, ub_base, res_base;
  logic [W-1:0] weight_sel;
  logic         busy, done, we_rl, ub_rd_en, res_we;
  logic [W-1:0] weight_addr;
  logic [A-1:0] ub_addr, res_addr;
`ifdef TPU_SEQ_PERF_CNT_EN
  logic [31:0]  perf_cycles;
`endif

  always #5 clk = ~clk;

  tpu_tile_sequencer #(.ADDRESSSIZE(A), .WADDR_BW(W), .PIPE_LAT(P)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .num_rows(num_rows), .ub_base(ub_base), .res_base(res_base), .weight_sel(weight_sel),
    .busy(busy), .done(done), .weight_addr(weight_addr), .we_rl(we_rl),
    .ub_rd_en(ub_rd_en), .ub_addr(ub_addr), .res_we(res_we), .res_addr(res_addr)
`ifdef TPU_SEQ_PERF_CNT_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  // Reference model: a job is a timeline indexed by k = cycles since the accept edge.
  bit          m_active;
  int          m_k, m_n, m_ub, m_res, m_wa;
  longint      m_perf;

  function automatic int job_end(input int n);
    return (n == 0) ? 3 : 3 + P + n;
  endfunction

  task automatic model_reset();
    m_active = 0; m_k = 0; m_n = 0; m_ub = 0; m_res = 0; m_wa = 0; m_perf = 0;
  endtask

  task automatic model_edge(input bit s, input bit ab, input int n, input int ub,
                            input int rb, input int ws);
    if (!m_active) begin
      if (s) begin
        m_active = 1; m_k = 1; m_n = n; m_ub = ub; m_res = rb; m_wa = ws; m_perf = 0;
      end
    end else begin
      if (m_perf < 64'hFFFF_FFFF) m_perf++;
      if (ab) m_wa = 0;
      if (m_k == job_end(m_n) || ab) m_active = 0;
      else m_k++;
    end
  endtask

  task automatic compare_all();
    bit e_rd, e_wr;
    int e_uba, e_ra;
    e_rd  = m_active && (m_k >= 3) && (m_k < 3 + m_n);
    e_wr  = m_active && (m_k >= 3 + P) && (m_k < 3 + P + m_n);
    e_uba = e_rd ? (m_ub + m_k - 3) % AMOD : 0;
    e_ra  = e_wr ? (m_res + m_k - 3 - P) % AMOD : 0;
    check("busy", 32'(busy), 32'(m_active));
    check("done", 32'(done), 32'(m_active && (m_k == job_end(m_n))));
    check("we_rl", 32'(we_rl), 32'(m_active && (m_k == 2)));
    check("weight_addr", 32'(weight_addr), 32'(m_wa));
    check("ub_rd_en", 32'(ub_rd_en), 32'(e_rd));
    check("ub_addr", 32'(ub_addr), 32'(e_uba));
    check("res_we", 32'(res_we), 32'(e_wr));
    check("res_addr", 32'(res_addr), 32'(e_ra));
`ifdef TPU_SEQ_PERF_CNT_EN
    check("perf_cycles", perf_cycles, 32'(m_perf));
`endif
  endtask

  // One clock: drive inputs, update the model at the edge, compare at the falling edge.
  task automatic step(input bit s, input bit ab, input int n, input int ub,
                      input int rb, input int ws);
    start = s; abort = ab;
    num_rows = A'(n); ub_base = A'(ub); res_base = A'(rb); weight_sel = W'(ws);
    @(posedge clk);
    model_edge(s, ab, n, ub, rb, ws);
    @(negedge clk);
    compare_all();
  endtask

  // Idle-cycle step with random data inputs, to show mid-job changes are ignored.
  task automatic step_noise(input bit s, input bit ab);
    step(s, ab, $urandom_range(0, AMOD - 1), $urandom_range(0, AMOD - 1),
         $urandom_range(0, AMOD - 1), $urandom_range(0, (1 << W) - 1));
  endtask

  task automatic run_job(input int n, input int ub, input int rb, input int ws, input int cycles);
    step(1, 0, n, ub, rb, ws);
    for (int i = 1; i < cycles; i++) step_noise(0, 0);
  endtask

  initial begin
    rstn = 1'b0; start = 0; abort = 0;
    num_rows = '0; ub_base = '0; res_base = '0; weight_sel = '0;
    model_reset();
    repeat (3) @(negedge clk);
    compare_all();
    rstn = 1'b1;

    // Basic job, then wrap, then zero rows.
    run_job(4, 100, 200, 2, 45);
`ifdef TPU_SEQ_PERF_CNT_EN
    check("perf_basic", perf_cycles, 32'd39);
`endif
    run_job(3, 1022, 1023, 1, 45);
    run_job(0, 5, 6, 3, 6);
    run_job(45, 1000, 990, 1, 90);

    // Second start while busy ignored, abort mid-job, immediate restart.
    for (int i = 0; i < 70; i++) begin
      if (i == 0) step(1, 0, 4, 100, 200, 2);
      else step_noise(i == 10 || i == 22, i == 20);
    end

    // Start held high across DONE re-launches immediately.
    step(1, 0, 2, 7, 9, 1);
    for (int i = 0; i < 40; i++) step(1, 0, 2, 7, 9, 1);
    for (int i = 0; i < 40; i++) step_noise(0, 0);

    // Async reset in the drain phase, then a clean repeat of the basic job.
    run_job(4, 100, 200, 2, 20);
    #2 rstn = 1'b0;
    model_reset();
    #1 compare_all();
    @(negedge clk);
    rstn = 1'b1;
    run_job(4, 100, 200, 2, 45);

    // Random traffic with occasional aborts.
    for (int i = 0; i < 3000; i++) begin
      int n;
      n = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 60);
      step(($urandom_range(0, 7) == 0), ($urandom_range(0, 299) == 0), n,
           $urandom_range(0, AMOD - 1), $urandom_range(0, AMOD - 1),
           $urandom_range(0, (1 << W) - 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
